// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned DIV_CYCLES_DEFAULT = 36;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_HOLD = 2'b10
  } div_state_e;

  // Enable/clear command applied to the PC and the four inter-stage registers.
  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic clr_d;
    logic clr_e;
    logic clr_m;
    logic clr_w;
  } stage_cmd_t;

  // Normal flow: every register advances.
  localparam stage_cmd_t CMD_RUN      = 9'b11111_0000;
  // Exception/eret: PC loads the redirect target, every stage register is cleared.
  localparam stage_cmd_t CMD_FLUSH    = 9'b11111_1111;
  // AXI access outstanding: the whole pipe freezes.
  localparam stage_cmd_t CMD_HALT     = 9'b00000_0000;
  // Divider busy: F/D/E hold, a bubble enters M, M/W drain.
  localparam stage_cmd_t CMD_DIV      = 9'b00011_0010;
  // Load-use: F/D hold, a bubble enters E.
  localparam stage_cmd_t CMD_LOAD_USE = 9'b00111_0100;

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Divider sequencer: tracks an iterative div/divu sitting in E and
// holds the result until E is allowed to advance.
module div_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start_e,
  input  logic adv_e,
  input  logic flush_now,
  output logic div_stall,
  output logic div_run,
  output logic div_done,
  output logic div_cancel
);

  localparam int unsigned CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on state, counter and the E-stage inputs, never on
  // adv_e, so the top-level priority mux can consume div_stall without a loop.
  always_comb begin
    div_stall  = 1'b0;
    div_run    = 1'b0;
    div_done   = 1'b0;
    div_cancel = 1'b0;
    unique case (state_q)
      DIV_IDLE: div_stall = div_start_e;
      DIV_BUSY: begin
        div_run    = 1'b1;
        div_done   = (cnt_q == '0);
        div_stall  = (cnt_q != '0);
        div_cancel = flush_now;
      end
      DIV_HOLD: begin
        div_done   = 1'b1;
        div_cancel = flush_now;
      end
      default: ;
    endcase
  end

  // Next-state logic; a flush always wins and leaves the counter cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_start_e && !flush_now) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        if (flush_now) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = adv_e ? DIV_IDLE : DIV_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_HOLD: begin
        if (flush_now) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (adv_e) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves memory
// stalls, divider stalls, load-use hazards and exception flushes into one
// enable/clear command per stage register each cycle.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  input  logic d_stall,
  input  logic ls_hazard_d,
  input  logic div_start_e,
  input  logic flush_req_m,
  output logic en_f,
  output logic en_d,
  output logic en_e,
  output logic en_m,
  output logic en_w,
  output logic clr_d,
  output logic clr_e,
  output logic clr_m,
  output logic clr_w,
  output logic flush_o,
  output logic div_run,
  output logic div_done,
  output logic div_cancel
);

  logic       mem_stall;
  logic       flush_now;
  logic       div_stall;
  logic       adv_e;
  logic       flush_pend_q, flush_pend_d;
  stage_cmd_t cmd;

  assign mem_stall = i_stall | d_stall;
  assign flush_now = (flush_req_m | flush_pend_q) & ~mem_stall;

  // Remembers a flush request that arrived while memory was stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  // Priority mux: flush > memory stall > divider > load-use > run.
  always_comb begin
    cmd          = CMD_RUN;
    flush_o      = 1'b0;
    flush_pend_d = flush_pend_q;
    if (flush_now) begin
      cmd          = CMD_FLUSH;
      flush_o      = 1'b1;
      flush_pend_d = 1'b0;
    end else if (mem_stall) begin
      cmd = CMD_HALT;
      if (flush_req_m) begin
        flush_pend_d = 1'b1;
      end
    end else if (div_stall) begin
      cmd = CMD_DIV;
    end else if (ls_hazard_d) begin
      cmd = CMD_LOAD_USE;
    end
  end

  assign adv_e = cmd.en_e & ~cmd.clr_e;

  assign en_f  = cmd.en_f;
  assign en_d  = cmd.en_d;
  assign en_e  = cmd.en_e;
  assign en_m  = cmd.en_m;
  assign en_w  = cmd.en_w;
  assign clr_d = cmd.clr_d;
  assign clr_e = cmd.clr_e;
  assign clr_m = cmd.clr_m;
  assign clr_w = cmd.clr_w;

  div_seq #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk         (clk),
    .rst         (rst),
    .div_start_e (div_start_e),
    .adv_e       (adv_e),
    .flush_now   (flush_now),
    .div_stall   (div_stall),
    .div_run     (div_run),
    .div_done    (div_done),
    .div_cancel  (div_cancel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process queues the
// hand-computed output word for each cycle, the monitor compares on negedge.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_stall = 1'b0, d_stall = 1'b0, ls_hazard_d = 1'b0;
  logic div_start_e = 1'b0, flush_req_m = 1'b0;
  logic en_f, en_d, en_e, en_m, en_w;
  logic clr_d, clr_e, clr_m, clr_w;
  logic flush_o, div_run, div_done, div_cancel;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .DIV_CYCLES (36)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (i_stall),
    .d_stall     (d_stall),
    .ls_hazard_d (ls_hazard_d),
    .div_start_e (div_start_e),
    .flush_req_m (flush_req_m),
    .en_f        (en_f),
    .en_d        (en_d),
    .en_e        (en_e),
    .en_m        (en_m),
    .en_w        (en_w),
    .clr_d       (clr_d),
    .clr_e       (clr_e),
    .clr_m       (clr_m),
    .clr_w       (clr_w),
    .flush_o     (flush_o),
    .div_run     (div_run),
    .div_done    (div_done),
    .div_cancel  (div_cancel)
  );

  // Word layout: {en_f,en_d,en_e,en_m,en_w, clr_d,clr_e,clr_m,clr_w, flush_o,div_run,div_done,div_cancel}
  logic [12:0] got;
  assign got = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w,
                flush_o, div_run, div_done, div_cancel};

  localparam logic [12:0] N   = {5'b11111, 4'b0000, 4'b0000};
  localparam logic [12:0] DS0 = {5'b00011, 4'b0010, 4'b0000};
  localparam logic [12:0] DSB = {5'b00011, 4'b0010, 4'b0100};
  localparam logic [12:0] DN  = {5'b11111, 4'b0000, 4'b0110};
  localparam logic [12:0] MS  = {5'b00000, 4'b0000, 4'b0000};
  localparam logic [12:0] MSD = {5'b00000, 4'b0000, 4'b0110};
  localparam logic [12:0] MSH = {5'b00000, 4'b0000, 4'b0010};
  localparam logic [12:0] HD  = {5'b11111, 4'b0000, 4'b0010};
  localparam logic [12:0] FL  = {5'b11111, 4'b1111, 4'b1000};
  localparam logic [12:0] FLC = {5'b11111, 4'b1111, 4'b1101};
  localparam logic [12:0] LS  = {5'b00111, 4'b0100, 4'b0000};

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [12:0] exp_q[$];
  string       tag_q[$];
  logic [12:0] m_exp;
  string       m_tag;

  // One cycle of stimulus: apply inputs just after posedge, queue the expectation.
  task automatic cyc(input logic r, input logic is, input logic ds, input logic ls,
                     input logic dv, input logic fl, input logic [12:0] e, input string tag);
    @(posedge clk);
    #1;
    rst         = r;
    i_stall     = is;
    d_stall     = ds;
    ls_hazard_d = ls;
    div_start_e = dv;
    flush_req_m = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare the presented outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_tag = tag_q.pop_front();
        total++;
        if (got !== m_exp) begin
          bad++;
          $display("FAIL %s got=%b exp=%b", m_tag, got, m_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // reset state
    cyc(0, 0, 0, 0, 0, 0, N, "reset");
    cyc(0, 0, 0, 0, 0, 0, N, "reset");
    // no hazards
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, N, "idle");

    // full divide: start cycle, 35 busy stall cycles, done cycle
    cyc(1, 0, 0, 0, 1, 0, DS0, "div_start");
    for (int i = 0; i < 35; i++) cyc(1, 0, 0, 0, 1, 0, DSB, "div_busy");
    cyc(1, 0, 0, 0, 1, 0, DN, "div_done");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, N, "div_after");

    // d_stall on the done cycle for 3 cycles -> HOLD, no re-issue
    cyc(1, 0, 0, 0, 1, 0, DS0, "hold_start");
    for (int i = 0; i < 35; i++) cyc(1, 0, 0, 0, 1, 0, DSB, "hold_busy");
    cyc(1, 0, 1, 0, 1, 0, MSD, "hold_done_mem");
    cyc(1, 0, 1, 0, 1, 0, MSH, "hold_mem");
    cyc(1, 0, 1, 0, 1, 0, MSH, "hold_mem");
    cyc(1, 0, 0, 0, 1, 0, HD, "hold_release");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, N, "hold_after");

    // flush requested under i_stall: deferred, single pulse
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 1, MS, "pend_stall");
    cyc(1, 0, 0, 0, 0, 0, FL, "pend_flush");
    cyc(1, 0, 0, 0, 0, 0, N, "pend_after");
    cyc(1, 0, 0, 0, 0, 0, N, "pend_after");

    // load-use hazard for one cycle
    cyc(1, 0, 0, 1, 0, 0, LS, "ls_hazard");
    cyc(1, 0, 0, 0, 0, 0, N, "ls_after");

    // direct flush in IDLE: no cancel pulse
    cyc(1, 0, 0, 0, 0, 1, FL, "flush_idle");
    cyc(1, 0, 0, 0, 0, 0, N, "flush_idle_after");

    // flush on the 20th busy cycle cancels the divide; restart later
    cyc(1, 0, 0, 0, 1, 0, DS0, "cxl_start");
    for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0, 1, 0, DSB, "cxl_busy");
    cyc(1, 0, 0, 0, 1, 1, FLC, "cxl_flush");
    cyc(1, 0, 0, 0, 0, 0, N, "cxl_gap");
    cyc(1, 0, 0, 0, 0, 0, N, "cxl_gap");
    cyc(1, 0, 0, 0, 1, 0, DS0, "restart");
    for (int i = 0; i < 35; i++) cyc(1, 0, 0, 0, 1, 0, DSB, "restart_busy");
    cyc(1, 0, 0, 0, 1, 0, DN, "restart_done");
    cyc(1, 0, 0, 0, 0, 0, N, "restart_after");

    // async reset mid-divide returns to idle with no stale done
    cyc(1, 0, 0, 0, 1, 0, DS0, "rst_start");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0, DSB, "rst_busy");
    cyc(0, 0, 0, 0, 0, 0, N, "rst_mid");
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0, 0, N, "rst_after");

    // pending flush cleared by async reset
    cyc(1, 0, 1, 0, 0, 1, MS, "rst_pend");
    cyc(0, 0, 0, 0, 0, 0, N, "rst_pend_clear");
    cyc(1, 0, 0, 0, 0, 0, N, "rst_pend_after");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain queue_left=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
